shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 170 +++++++++++++++++
 tb/tb_shift_add_multiplier.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N shift-and-add multiplier.
// One conditional add plus right shift per clock through an N-bit ripple
// adder; valid/ready handshakes on the operand and result sides.
// Optional build macro SHIFT_ADD_MULT_EARLY_TERM_EN: once the unconsumed
// multiplier bits are all zero, the remaining shifts are done in one cycle.

module ripple_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         c_out,
  output logic [N-1:0] sum
);

  logic [N:0] carry;

  assign carry[0] = c_in;

  // Full-adder chain, carry rippling from bit 0 upward.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[N];

endmodule

module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);
  localparam int PW = 2 * N;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [N-1:0]   mcand;
  logic [N-1:0]   acc_hi;
  logic [N-1:0]   acc_lo;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   add_b;
  logic [N-1:0]   add_sum;
  logic           add_c_out;
  logic [PW:0]    wide;
  logic [PW-1:0]  acc_next;
  logic           last_step;

  // The multiplicand is added only when the multiplier bit now at acc_lo[0] is set.
  assign add_b = acc_lo[0] ? mcand : '0;

  ripple_adder #(.N(N)) u_adder (
    .a     (acc_hi),
    .b     (add_b),
    .c_in  (1'b0),
    .c_out (add_c_out),
    .sum   (add_sum)
  );

  // Carry, partial sum and remaining multiplier bits form one (2N+1)-bit word.
  assign wide = {add_c_out, add_sum, acc_lo};

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
  logic [N-1:0] rem_mask;
  logic         rem_zero;
  int           shamt;

  // Unconsumed multiplier bits sit in acc_lo[N-1-cnt:1]; when they are all zero,
  // the rest of the work is alignment, done as one wider shift.
  always_comb begin
    rem_mask = {N{1'b1}} >> (int'(cnt) + 1);
    rem_zero = ((acc_lo >> 1) & rem_mask) == '0;
    shamt    = rem_zero ? (N - int'(cnt)) : 1;
  end

  assign acc_next  = PW'(wide >> shamt);
  assign last_step = rem_zero;
`else
  assign acc_next  = PW'(wide >> 1);
  assign last_step = (cnt == CW'(N - 1));
`endif

  assign product = {acc_hi, acc_lo};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: non-blocking assignment keeps every flop updating from the
      // pre-edge values, regardless of block ordering.
      state <= next_state;
    end
  end

  // Next-state decode and operand-side ready.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    next_state = state;
    in_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = CALC;
      end
      CALC: begin
        if (last_step) next_state = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, add-and-shift steps and result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a;
            acc_lo <= b;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          {acc_hi, acc_lo} <= acc_next;
          cnt              <= cnt + 1'b1;
        end
        DONE: begin
          // First DONE cycle raises out_valid; the product is already stable.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: an N=8 and an N=4 instance.
// Expected products and latencies come from plain arithmetic on the operands.
`timescale 1ns/1ps

module tb_shift_add_multiplier;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    longint unsigned prod;
    int              lat;
    int              acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // N = 8 instance
  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;

  shift_add_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .product(p8)
  );

  // N = 4 instance
  logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b1;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  p4;

  shift_add_multiplier #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .product(p4)
  );

  exp_t q8[$];
  exp_t q4[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   seen8 = 1'b0, seen4 = 1'b0;
  bit   rand_bp = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference latency: N+1 cycles, or (MSB index of b)+2 with early termination.
  function automatic int exp_lat(input int n, input int bv);
    if (!EARLY) return n + 1;
    for (int i = n - 1; i >= 0; i--) if (bv[i]) return i + 2;
    return 2;
  endfunction

  // Monitor for the N=8 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen8 = 1'b0;
    end else if (ov8) begin
      if (q8.size() == 0) begin
        check("spurious_out8", ov8, 0);
      end else begin
        if (!seen8) begin
          check("latency8", cyc - q8[0].acc_cyc, q8[0].lat);
          seen8 = 1'b1;
        end
        check("product8", p8, q8[0].prod);
        if (or8) begin
          void'(q8.pop_front());
          seen8 = 1'b0;
        end
      end
    end
  end

  // Monitor for the N=4 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen4 = 1'b0;
    end else if (ov4) begin
      if (q4.size() == 0) begin
        check("spurious_out4", ov4, 0);
      end else begin
        if (!seen4) begin
          check("latency4", cyc - q4[0].acc_cyc, q4[0].lat);
          seen4 = 1'b1;
        end
        check("product4", p4, q4[0].prod);
        if (or4) begin
          void'(q4.pop_front());
          seen4 = 1'b0;
        end
      end
    end
  end

  // Random consumer back-pressure during the random phase.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1 or8 = 1'($urandom_range(0, 1));
    end
  end

  task automatic send8(input logic [7:0] av, input logic [7:0] bv);
    int t = 0;
    a8 = av; b8 = bv; iv8 = 1'b1;
    forever begin
      @(negedge clk);
      if (ir8) break;
      if (++t > 300) begin
        check("accept_timeout8", ir8, 1);
        iv8 = 1'b0;
        return;
      end
    end
    q8.push_back('{longint'(av) * longint'(bv), exp_lat(8, int'(bv)), cyc + 1});
    @(posedge clk);
    #1 iv8 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] av, input logic [3:0] bv);
    int t = 0;
    a4 = av; b4 = bv; iv4 = 1'b1;
    forever begin
      @(negedge clk);
      if (ir4) break;
      if (++t > 300) begin
        check("accept_timeout4", ir4, 1);
        iv4 = 1'b0;
        return;
      end
    end
    q4.push_back('{longint'(av) * longint'(bv), exp_lat(4, int'(bv)), cyc + 1});
    @(posedge clk);
    #1 iv4 = 1'b0;
  endtask

  task automatic drain8();
    int t = 0;
    while (q8.size() != 0) begin
      @(negedge clk);
      if (++t > 500) begin
        check("drain_timeout8", q8.size(), 0);
        q8.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain4();
    int t = 0;
    while (q4.size() != 0) begin
      @(negedge clk);
      if (++t > 500) begin
        check("drain_timeout4", q4.size(), 0);
        q4.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ra, rb;
    int         t;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready8", ir8, 1);
    check("rst_out_valid8", ov8, 0);
    check("rst_product8", p8, 0);
    check("rst_in_ready4", ir4, 1);
    check("rst_out_valid4", ov4, 0);
    check("rst_product4", p4, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed products
    send8(8'd13, 8'd11);
    drain8();
    send8(8'd255, 8'd255);
    drain8();
    send8(8'd200, 8'd0);
    drain8();

    // Back-pressure: result held 5 cycles while busy-time in_valid pulses are ignored
    or8 = 1'b0;
    send8(8'd7, 8'd9);
    t = 0;
    while (!ov8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid_seen", ov8, 1);
    repeat (5) begin
      @(posedge clk);
      #1 iv8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
      @(negedge clk);
      check("bp_hold_valid", ov8, 1);
      check("bp_in_ready_low", ir8, 0);
    end
    @(posedge clk);
    #1 iv8 = 1'b0; or8 = 1'b1;
    drain8();
    send8(8'd6, 8'd21);
    drain8();

    // Reset in the third CALC cycle aborts the operation
    send8(8'd100, 8'd100);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_in_ready", ir8, 1);
    check("abort_out_valid", ov8, 0);
    check("abort_product", p8, 0);
    q8.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send8(8'd3, 8'd5);
    drain8();

    // Random operands with random back-pressure; sparse multipliers exercise early exit
    rand_bp = 1'b1;
    repeat (30) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      send8(ra, rb);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2 or8 = 1'b1;
    drain8();

    // N = 4 instance
    send4(4'd15, 4'd15);
    drain4();
    send4(4'd15, 4'd1);
    drain4();
    send4(4'd9, 4'd0);
    drain4();
    repeat (10) begin
      send4(4'($urandom), 4'($urandom));
    end
    drain4();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
